// File: rtl/ttriger_pkg.sv
// Shared types and helpers for the T flip-flop period meter.
// Measurement FSM states, default counter width, saturating increment.
package ttriger_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Chain resets to 0; output is the last stage.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ttriger_period_meter.sv
// Measures high/low time and period of a resynchronised toggle signal.
// Publishes one registered measurement per complete period.
module ttriger_period_meter
  import ttriger_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_ovf,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic             w_fall;
  meas_state_t      r_state;
  meas_state_t      w_next;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic             r_ovf;
  logic [CNT_W-1:0] w_hinc;
  logic [CNT_W-1:0] w_linc;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst),
    .i_d  (q_in),
    .o_q  (w_s)
  );

  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_hinc = CNT_W'(sat_inc(32'(r_hcnt), 32'(CMAX)));
  assign w_linc = CNT_W'(sat_inc(32'(r_lcnt), 32'(CMAX)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_rise) w_next = HIGH;
      HIGH:    if (w_fall) w_next = LOW;
      LOW:     if (w_rise) w_next = HIGH;
      default: w_next = IDLE;
    endcase
  end

  // clr clears everything except the synchroniser and s_d
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_d      <= 1'b0;
      r_state    <= IDLE;
      r_hcnt     <= '0;
      r_lcnt     <= '0;
      r_ovf      <= 1'b0;
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      meas_ovf   <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      r_s_d <= w_s;
      if (clr) begin
        r_state    <= IDLE;
        r_hcnt     <= '0;
        r_lcnt     <= '0;
        r_ovf      <= 1'b0;
        meas_valid <= 1'b0;
        high_cnt   <= '0;
        low_cnt    <= '0;
        period     <= '0;
        meas_ovf   <= 1'b0;
        edge_cnt   <= '0;
      end else begin
        meas_valid <= 1'b0;
        r_state    <= w_next;
        if (w_rise || w_fall) begin
          edge_cnt <= edge_cnt + ONE;
        end
        unique case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_hcnt <= ONE;
              r_ovf  <= 1'b0;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_lcnt <= ONE;
            end else begin
              r_hcnt <= w_hinc;
              if (r_hcnt == CMAX) r_ovf <= 1'b1;
            end
          end
          LOW: begin
            if (w_rise) begin
              high_cnt   <= r_hcnt;
              low_cnt    <= r_lcnt;
              period     <= {1'b0, r_hcnt} + {1'b0, r_lcnt};
              meas_ovf   <= r_ovf;
              meas_valid <= 1'b1;
              r_hcnt     <= ONE;
              r_ovf      <= 1'b0;
            end else begin
              r_lcnt <= w_linc;
              if (r_lcnt == CMAX) r_ovf <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ttriger_period_meter.md
# ttriger_period_meter

Downstream measurement stage for the asynchronous-reset T flip-flop output. Resynchronises the toggling `q` signal into its own clock domain, detects edges and measures high time, low time and full period in clock cycles. It publishes one measurement per complete period with a single-cycle valid strobe. It also keeps a free-running edge count for bring-up and debug.

## Interface
Parameters:
- `CNT_W`, 16: width of `high_cnt`, `low_cnt` and `edge_cnt`.
- `SYNC_STAGES`, 2: number of input synchroniser flops; legal range 2..4.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-low reset.
- `q_in`  in  1: T flip-flop output; treated as asynchronous.
- `clr`  in  1: synchronous clear; returns the block to its reset state.
- `meas_valid`  out  1: one-cycle strobe; a new measurement is on the outputs.
- `high_cnt`  out  CNT_W: cycles the synchronised input was high in the last period.
- `low_cnt`  out  CNT_W: cycles the synchronised input was low in the last period.
- `period`  out  CNT_W+1: `high_cnt + low_cnt`; no truncation.
- `meas_ovf`  out  1: the published measurement saturated at least one counter.
- `edge_cnt`  out  CNT_W: total rising plus falling edges seen; wraps modulo 2^CNT_W.

## Operation
- **Reset values.** `rst` low asynchronously forces the following to 0: the synchroniser chain, `s_d`, the FSM (to IDLE), the internal counters and every output.
- **Synchronisation and edge detect.**
  - `s` is the last synchroniser stage; `s_d` is `s` delayed by one cycle.
  - `rise = s & ~s_d`; `fall = ~s & s_d`.
- **FSM states:** IDLE, HIGH, LOW.
  - **IDLE:**
    - on `rise`: go to HIGH, `hcnt <= 1`, `ovf <= 0`.
    - on `fall`: ignored.
    - This discards the first partial period.
  - **HIGH:**
    - on `fall`: go to LOW, `lcnt <= 1`.
    - otherwise: `hcnt <= hcnt + 1`.
  - **LOW:**
    - on `rise`: register `high_cnt <= hcnt`, `low_cnt <= lcnt`, `period <= hcnt + lcnt`, `meas_ovf <= ovf`. Pulse `meas_valid`. Go to HIGH with `hcnt <= 1`, `ovf <= 0`.
    - otherwise: `lcnt <= lcnt + 1`.
- **Saturation.** `hcnt` and `lcnt` saturate at 2^CNT_W-1. Any increment attempted at that maximum sets the internal `ovf` bit.
- **Output hold.** `high_cnt`, `low_cnt`, `period` and `meas_ovf` hold their values until the next publish or clear.
- **Edge count.** `edge_cnt` increments on every `rise` or `fall` in any state, including IDLE, and wraps.
- **`clr` behaviour.** `clr` high has the same effect as reset, applied synchronously. It takes priority over a simultaneous edge, so that edge is not counted. The synchroniser chain and `s_d` are not cleared.
- **Reset mid-measurement.** The partial measurement is lost and no `meas_valid` is produced for it.

## Timing
- Latency from `q_in` to `s`: SYNC_STAGES rising `clk` edges.
- Latency from `s` to `meas_valid`: 1 cycle. The strobe is registered on the edge where `rise` is true.
- Total latency from the `q_in` rising sample edge to `meas_valid` high: SYNC_STAGES+1 cycles.
- `meas_valid` is high for exactly one cycle per completed period.
- Minimum input period that can be measured: 2 cycles (high 1, low 1). This gives one publish every 2 cycles.
- Input pulses shorter than one clock may be missed. The block does not detect this.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `ttriger_pkg`:
  - `meas_state_t` enum (IDLE, HIGH, LOW).
  - Default `CNT_W` constant.
  - Saturating-increment function.
- Sub-module `bit_synchronizer`: parameterised by SYNC_STAGES, with async active-low reset to 0. Instantiated once.
- Everything else lives in one always_ff block with the FSM plus counters.

## Test plan
- **Reset:** `rst` low with `q_in` toggling. All outputs read 0. Release `rst`: there is no `meas_valid` until one full period after the first rise.
- **Square wave, high 1 / low 1:** `q_in` is the T flip-flop output with `data = 1`. Expect `meas_valid` every 2 cycles with `high_cnt = 1`, `low_cnt = 1`, `period = 2`. `edge_cnt` increases by 2 per publish.
- **Asymmetric wave:** high 5, low 3 cycles. Expect `high_cnt = 5`, `low_cnt = 3`, `period = 8`, `meas_ovf = 0`. `meas_valid` appears SYNC_STAGES+1 cycles after each `q_in` rise.
- **Saturation:** CNT_W = 4, `q_in` high 20 and low 2 cycles. Expect `high_cnt = 15`, `low_cnt = 2`, `period = 17`, `meas_ovf = 1`. The next normal period publishes `meas_ovf = 0`.
- **`clr` mid-HIGH:** assert `clr` in the same cycle as a `fall`. Outputs go to 0 and `edge_cnt` stays 0. The FSM returns to IDLE, and the next publish needs a fresh rise-fall-rise.
- **Wrap:** CNT_W = 4, drive 17 edges. Expect `edge_cnt = 1`.
